// File: rtl/fifo_write_arbiter_if.sv
// Shared FIFO write-port bundle: producer request/grant lines plus the FIFO write/status pins.
// master is the arbiter side; slave is the producers together with the FIFO.
interface fifo_write_arbiter_if #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_wr_en;
  logic                          fifo_full;
  logic                          fifo_almostfull;
  logic                          fifo_wr_ack;
  logic                          fifo_overflow;

  modport master (
    input  req, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    output gnt, fifo_data_in, fifo_wr_en
  );

  modport slave (
    output req, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    input  gnt, fifo_data_in, fifo_wr_en
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, with
// full/almostfull throttling and a saturating counter of writes the FIFO failed to ack.
module fifo_write_arbiter #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned CNT_WIDTH  = 8,
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  fifo_write_arbiter_if.master    bus,
  output logic                    stall_o,
  output logic [CNT_WIDTH-1:0]    drop_count_o,
  output logic [ID_W-1:0]         drop_id_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_e;

  state_e                  state_q;
  logic [NUM_REQ-1:0]      gnt_q;
  logic                    wr_en_q;
  logic [FIFO_WIDTH-1:0]   data_q;
  logic [ID_W-1:0]         last_q;
  logic                    pending_q;
  logic [ID_W-1:0]         pend_id_q;
  logic [CNT_WIDTH-1:0]    drop_count_q;
  logic [ID_W-1:0]         drop_id_q;

  logic [NUM_REQ-1:0]      elig;
  logic                    elig_any;
  logic                    can_issue;
  logic                    issue;
  logic                    found;
  logic [ID_W-1:0]         winner;
  logic [FIFO_WIDTH-1:0]   win_data;
  logic                    unused_ovf;

  // Overflow is informational only; drops are detected from a missing wr_ack.
  assign unused_ovf = bus.fifo_overflow;

  // A write in flight into an almost-full FIFO fills it, so it blocks the next issue.
  assign can_issue = en_i & ~bus.fifo_full & ~(wr_en_q & bus.fifo_almostfull);
  assign elig      = bus.req & ~gnt_q;
  assign elig_any  = |elig;
  assign issue     = elig_any & can_issue;

  // Rotating-priority search starting just after the last winner.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      int unsigned idx;
      idx = (32'(last_q) + k) % NUM_REQ;
      if (!found && elig[ID_W'(idx)]) begin
        winner = ID_W'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) win_data = bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      wr_en_q      <= 1'b0;
      data_q       <= '0;
      last_q       <= ID_W'(NUM_REQ - 1);
      pending_q    <= 1'b0;
      pend_id_q    <= '0;
      drop_count_q <= '0;
      drop_id_q    <= '0;
    end else begin
      if (issue) begin
        wr_en_q <= 1'b1;
        gnt_q   <= NUM_REQ'(1) << winner;
        data_q  <= win_data;
        last_q  <= winner;
      end else begin
        wr_en_q <= 1'b0;
        gnt_q   <= '0;
      end

      // The FIFO answers a write with wr_ack one cycle after capturing it.
      pending_q <= wr_en_q;
      if (wr_en_q) pend_id_q <= last_q;

      if (pending_q && !bus.fifo_wr_ack) begin
        if (drop_count_q != '1) drop_count_q <= drop_count_q + CNT_WIDTH'(1);
        drop_id_q <= pend_id_q;
      end

      if (!elig_any)      state_q <= IDLE;
      else if (can_issue) state_q <= ISSUE;
      else                state_q <= STALL;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_data_in = data_q;
  assign stall_o          = (state_q == STALL);
  assign drop_count_o     = drop_count_q;
  assign drop_id_o        = drop_id_q;

endmodule
